// File: rtl/adder_bench_pkg.sv
// Shared types and constants for the adder operand sequencer.
package adder_bench_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_SETTLE,
        ST_CHECK,
        ST_RADDR,
        ST_RSAMP,
        ST_DONE
    } seq_state_t;

    // Fibonacci taps 16,14,13,11 expressed as a mask on state bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;

    // First pair of every run ripples a carry through all eight bit positions
    localparam logic [7:0]  FIRST_OPR_A = 8'h01;
    localparam logic [7:0]  FIRST_OPR_B = 8'hFF;

    localparam int          CNT_W       = 32;

    // One left-shift step; feedback is the XOR of the tapped bits
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR operand source with seed reload and zero-seed fixup.
module lfsr16
    import adder_bench_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset_L,
    input  logic        load,
    input  logic        advance,
    output logic [15:0] state
);

    // An all-zero state would lock the register, so a zero seed becomes 1
    localparam logic [15:0] SEED_FIX = (SEED == 16'h0000) ? 16'h0001 : SEED;

    // Reload takes priority over advancing
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state <= SEED_FIX;
        end else if (load) begin
            state <= SEED_FIX;
        end else if (advance) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/adder_op_sequencer.sv
// Clears the transition-counter memory, drives operand pairs to the adder
// under test, checks {carry,sum} after a settle time, then streams the
// counters back out.
module adder_op_sequencer
    import adder_bench_pkg::*;
#(
    parameter int          N_OPS  = 5000,
    parameter int          SETTLE = 4,
    parameter int          NCNT   = 3,
    parameter int          DIR_W  = 2,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [7:0]       opr_a,
    output logic [7:0]       opr_b,
    input  logic [7:0]       sum_in,
    input  logic             co_in,
    output logic [15:0]      op_cnt,
    output logic [15:0]      err_cnt,
    output logic [DIR_W-1:0] mem_dir,
    output logic             mem_le,
    output logic [CNT_W-1:0] mem_wdata,
    input  logic [CNT_W-1:0] mem_rdata,
    output logic             rd_valid,
    output logic [DIR_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_data
);

    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    seq_state_t       state;
    seq_state_t       state_next;
    logic             lfsr_load;
    logic             lfsr_adv;
    logic [15:0]      lfsr_state;
    logic [SET_W-1:0] settle_cnt;
    logic [8:0]       golden;
    logic             mismatch;
    logic             last_dir;
    logic             last_op;

    // Error count sticks at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    lfsr16 #(
        .SEED    (SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset_L (reset_L),
        .load    (lfsr_load),
        .advance (lfsr_adv),
        .state   (lfsr_state)
    );

    assign mem_wdata = '0;
    assign golden    = {1'b0, opr_a} + {1'b0, opr_b};
    assign mismatch  = ({co_in, sum_in} != golden);
    assign last_dir  = (mem_dir == DIR_W'(NCNT - 1));
    assign last_op   = (op_cnt == 16'(N_OPS - 1));

    // State register
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and LFSR control strobes
    always_comb begin
        state_next = state;
        lfsr_load  = 1'b0;
        lfsr_adv   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_CLEAR;
                    lfsr_load  = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (last_dir) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_next = ST_SETTLE;
                // The first pair is the fixed carry-ripple pattern; the LFSR
                // only advances once it has supplied a pair
                lfsr_adv   = (op_cnt != 16'd0);
            end
            ST_SETTLE: begin
                if (settle_cnt == '0) begin
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_next = last_op ? ST_RADDR : ST_LOAD;
            end
            ST_RADDR: begin
                state_next = ST_RSAMP;
            end
            ST_RSAMP: begin
                state_next = last_dir ? ST_DONE : ST_RADDR;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Registered outputs, counters and memory addressing per state
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            opr_a      <= '0;
            opr_b      <= '0;
            op_cnt     <= '0;
            err_cnt    <= '0;
            mem_dir    <= '0;
            mem_le     <= 1'b1;
            rd_valid   <= 1'b0;
            rd_idx     <= '0;
            rd_data    <= '0;
            settle_cnt <= '0;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        op_cnt  <= '0;
                        err_cnt <= '0;
                        mem_le  <= 1'b0;
                        mem_dir <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (last_dir) begin
                        mem_le <= 1'b1;
                    end else begin
                        mem_dir <= mem_dir + DIR_W'(1);
                    end
                end
                ST_LOAD: begin
                    if (op_cnt == 16'd0) begin
                        opr_a <= FIRST_OPR_A;
                        opr_b <= FIRST_OPR_B;
                    end else begin
                        opr_a <= lfsr_state[15:8];
                        opr_b <= lfsr_state[7:0];
                    end
                    settle_cnt <= SET_W'(SETTLE - 1);
                end
                ST_SETTLE: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - SET_W'(1);
                    end
                end
                ST_CHECK: begin
                    op_cnt <= op_cnt + 16'd1;
                    if (mismatch) begin
                        err_cnt <= sat_inc16(err_cnt);
                    end
                    if (last_op) begin
                        mem_dir <= '0;
                    end
                end
                ST_RADDR: begin
                    mem_le <= 1'b1;
                end
                ST_RSAMP: begin
                    rd_data  <= mem_rdata;
                    rd_valid <= 1'b1;
                    rd_idx   <= mem_dir;
                    if (last_dir) begin
                        done <= 1'b1;
                    end else begin
                        mem_dir <= mem_dir + DIR_W'(1);
                    end
                end
                ST_DONE: begin
                    busy <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_op_sequencer.sv
// Self-checking bench for adder_op_sequencer: adder and counter-memory
// models, table-driven runs with operand/readout scoreboards, plus
// mid-run reset and zero-seed LFSR sequences.
module tb_adder_op_sequencer;

    localparam int N_OPS     = 4;
    localparam int SETTLE    = 2;
    localparam int NCNT      = 3;
    localparam int DIR_W     = 2;
    localparam int BUSY_EXP  = NCNT + N_OPS * (SETTLE + 2) + 2 * NCNT + 1;

    logic             clk = 1'b0;
    logic             reset_L = 1'b0;
    logic             start = 1'b0;
    logic             busy, done;
    logic [7:0]       opr_a, opr_b;
    logic [7:0]       sum_in;
    logic             co_in;
    logic [15:0]      op_cnt, err_cnt;
    logic [DIR_W-1:0] mem_dir;
    logic             mem_le;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata;
    logic             rd_valid;
    logic [DIR_W-1:0] rd_idx;
    logic [31:0]      rd_data;

    always #5 clk = ~clk;

    adder_op_sequencer #(
        .N_OPS   (N_OPS),
        .SETTLE  (SETTLE),
        .NCNT    (NCNT),
        .DIR_W   (DIR_W),
        .SEED    (16'hACE1)
    ) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .opr_a     (opr_a),
        .opr_b     (opr_b),
        .sum_in    (sum_in),
        .co_in     (co_in),
        .op_cnt    (op_cnt),
        .err_cnt   (err_cnt),
        .mem_dir   (mem_dir),
        .mem_le    (mem_le),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .rd_valid  (rd_valid),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data)
    );

    // Zero-seed LFSR instance for the seed fixup check
    logic        lz_load = 1'b0;
    logic        lz_adv  = 1'b0;
    logic [15:0] lz_state;

    lfsr16 #(.SEED(16'h0000)) u_lfsr_zero (
        .clk     (clk),
        .reset_L (reset_L),
        .load    (lz_load),
        .advance (lz_adv),
        .state   (lz_state)
    );

    // Registered adder model; fault forces sum bit 0 low
    logic       fault = 1'b0;
    logic [8:0] add_q = '0;
    always @(posedge clk) add_q <= {1'b0, opr_a} + {1'b0, opr_b};
    assign sum_in = fault ? {add_q[7:1], 1'b0} : add_q[7:0];
    assign co_in  = add_q[8];

    // Counter memory model; bypass suppresses the CLEAR writes
    logic [31:0] mem [0:3];
    logic        preset = 1'b0;
    logic        bypass = 1'b0;
    always @(posedge clk) begin
        if (preset) begin
            mem[0] <= 32'd7;
            mem[1] <= 32'd8;
            mem[2] <= 32'd9;
            mem[3] <= 32'd10;
        end else if (!mem_le && !bypass) begin
            mem[mem_dir] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_dir];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [33:0] got, input logic [33:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got event-missing, expected event", name);
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    typedef struct {
        bit          fault;
        bit          bypass;
        bit          hold;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [31:0] rd2;
        int          busy_exp;
    } run_t;

    run_t        tbl [4];
    logic [15:0] pair_q [$];
    logic [33:0] rd_q   [$];

    task automatic run_case(input run_t r, input string tag);
        logic [15:0] s;
        logic [15:0] p;
        logic [33:0] e;
        logic [15:0] prev_op;
        int          exp_err;
        int          busy_n;
        int          done_n;
        int          extra_busy;
        bit          finished;
        pair_q.delete();
        rd_q.delete();
        s       = 16'hACE1;
        exp_err = 0;
        for (int i = 0; i < N_OPS; i++) begin
            if (i == 0) begin
                p = 16'h01FF;
            end else begin
                p = s;
                s = lfsr_next(s);
            end
            pair_q.push_back(p);
            if (r.fault && (p[8] ^ p[0])) exp_err++;
        end
        rd_q.push_back({2'd0, r.rd0});
        rd_q.push_back({2'd1, r.rd1});
        rd_q.push_back({2'd2, r.rd2});
        fault  = r.fault;
        bypass = r.bypass;
        @(negedge clk) preset = 1'b1;
        @(negedge clk) preset = 1'b0;
        start      = 1'b1;
        busy_n     = 0;
        done_n     = 0;
        extra_busy = 0;
        prev_op    = '0;
        finished   = 1'b0;
        for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
            @(negedge clk);
            if (cyc == 0 && !r.hold) start = 1'b0;
            if (busy) busy_n++;
            if (op_cnt != prev_op) begin
                prev_op = op_cnt;
                if (pair_q.size() == 0) begin
                    fail_now({tag, "_extra_pair"});
                end else begin
                    p = pair_q.pop_front();
                    check({tag, "_pair"}, {18'd0, opr_a, opr_b}, {18'd0, p});
                end
            end
            if (rd_valid) begin
                if (rd_q.size() == 0) begin
                    fail_now({tag, "_extra_read"});
                end else begin
                    e = rd_q.pop_front();
                    check({tag, "_readout"}, {rd_idx, rd_data}, e);
                end
            end
            if (done) begin
                done_n++;
                finished = 1'b1;
                if (r.hold) start = 1'b0;
            end
        end
        if (!finished) fail_now({tag, "_done_timeout"});
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) done_n++;
            if (busy) extra_busy++;
        end
        check({tag, "_done_pulses"}, 34'(done_n), 34'd1);
        check({tag, "_no_restart"}, 34'(extra_busy), 34'd0);
        check({tag, "_busy_cycles"}, 34'(busy_n), 34'(r.busy_exp));
        check({tag, "_op_cnt"}, {18'd0, op_cnt}, 34'(N_OPS));
        check({tag, "_err_cnt"}, {18'd0, err_cnt}, 34'(exp_err));
        check({tag, "_queues_empty"}, 34'(pair_q.size() + rd_q.size()), 34'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] s;
        int          mism;
        int          zeros;

        tbl[0] = '{fault: 1'b0, bypass: 1'b0, hold: 1'b0, rd0: 32'd0, rd1: 32'd0, rd2: 32'd0, busy_exp: BUSY_EXP};
        tbl[1] = '{fault: 1'b1, bypass: 1'b0, hold: 1'b0, rd0: 32'd0, rd1: 32'd0, rd2: 32'd0, busy_exp: BUSY_EXP};
        tbl[2] = '{fault: 1'b0, bypass: 1'b1, hold: 1'b0, rd0: 32'd7, rd1: 32'd8, rd2: 32'd9, busy_exp: BUSY_EXP};
        tbl[3] = '{fault: 1'b0, bypass: 1'b1, hold: 1'b1, rd0: 32'd7, rd1: 32'd8, rd2: 32'd9, busy_exp: BUSY_EXP};

        repeat (3) @(negedge clk);
        check("reset_opr", {18'd0, opr_a, opr_b}, 34'd0);
        check("reset_flags", {29'd0, busy, done, rd_valid, mem_le, 1'b0}, 34'b00010);
        reset_L = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run_case(tbl[i], $sformatf("run%0d", i));
        end

        // Reset asserted during SETTLE of the second pair
        fault  = 1'b0;
        bypass = 1'b0;
        start  = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 100 && op_cnt != 16'd1; i++) @(negedge clk);
        if (op_cnt != 16'd1) fail_now("midrun_wait_timeout");
        @(negedge clk);
        @(negedge clk);
        check("midrun_pair2", {18'd0, opr_a, opr_b}, {18'd0, 16'hACE1});
        reset_L = 1'b0;
        #1;
        check("rst_opr", {18'd0, opr_a, opr_b}, 34'd0);
        check("rst_cnts", {2'd0, op_cnt, err_cnt}, 34'd0);
        check("rst_mem_dir_le", {31'd0, mem_dir, mem_le}, 34'd1);
        check("rst_wdata", {2'd0, mem_wdata}, 34'd0);
        check("rst_flags", {29'd0, busy, done, rd_valid, rd_idx}, 34'd0);
        check("rst_rd_data", {2'd0, rd_data}, 34'd0);
        @(negedge clk);
        @(negedge clk) reset_L = 1'b1;
        @(negedge clk);
        run_case(tbl[0], "after_reset");

        // Zero seed: loads as 16'h0001 and never reaches the all-zero state
        @(negedge clk) lz_load = 1'b1;
        @(negedge clk) lz_load = 1'b0;
        check("zero_seed_first_pair", {18'd0, lz_state}, {18'd0, 16'h0001});
        s     = 16'h0001;
        mism  = 0;
        zeros = 0;
        lz_adv = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            s = lfsr_next(s);
            if (lz_state !== s) mism++;
            if (lz_state == 16'h0000) zeros++;
        end
        lz_adv = 1'b0;
        check("zero_seed_sequence", 34'(mism), 34'd0);
        check("zero_seed_no_lockup", 34'(zeros), 34'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
